// File: rtl/alarm_timekeeper.sv
// Time-of-day counter and alarm FSM clocked by clk, counting rising edges of clk_100hz.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_timekeeper #(
    parameter int TICKS_PER_SEC  = 100,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_100hz,
    input  logic       set_en,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_arm,
    input  logic       stop,
    input  logic       snooze,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_pulse,
    output logic       alarm_ring
);

    localparam int SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RING_W = $clog2(RING_SECONDS + 1);
    localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [RING_W-1:0] RING_MAX = RING_W'(RING_SECONDS - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SNOOZE_SECS = SNOOZE_MINUTES * 60;
    localparam int SNZ_W       = $clog2(SNOOZE_SECS + 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX = SNZ_W'(SNOOZE_SECS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;
`else
    localparam int SNOOZE_MINUTES_UNUSED = SNOOZE_MINUTES;
    logic snooze_unused;
    assign snooze_unused = snooze;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1
    } state_t;
`endif

    // sync_q[0..1] are the synchronizer, sync_q[2] holds the previous sample for edge detect
    logic [2:0]       sync_q;
    logic             tick;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [4:0]       hh_q, hh_d;
    logic [5:0]       mm_q, mm_d, ss_q, ss_d;
    logic             sec_adv;
    logic             sec_pulse_q;
    logic             match_d, match_q;
    state_t           state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
`endif

    assign tick = sync_q[1] & ~sync_q[2];

    always_comb begin
        sub_d   = sub_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        sec_adv = 1'b0;
        if (set_en) begin
            hh_d  = (set_hh > 5'd23) ? 5'd23 : set_hh;
            mm_d  = (set_mm > 6'd59) ? 6'd59 : set_mm;
            ss_d  = 6'd0;
            sub_d = '0;
        end else if (tick) begin
            if (sub_q == SUB_MAX) begin
                sub_d   = '0;
                sec_adv = 1'b1;
                if (ss_q == 6'd59) begin
                    ss_d = 6'd0;
                    if (mm_q == 6'd59) begin
                        mm_d = 6'd0;
                        hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // A match only comes from counting into the alarm minute, never from a load
    assign match_d = sec_adv && alarm_arm && (ss_d == 6'd0) &&
                     (mm_d == alarm_mm) && (hh_d == alarm_hh);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 3'b000;
            sub_q       <= '0;
            hh_q        <= 5'd0;
            mm_q        <= 6'd0;
            ss_q        <= 6'd0;
            sec_pulse_q <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], clk_100hz};
            sub_q       <= sub_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            sec_pulse_q <= sec_adv;
            match_q     <= match_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (match_q) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = '0;
                end
            end
            ST_RINGING: begin
                if (stop || !alarm_arm) begin
                    state_d = ST_IDLE;
                end else if (sec_adv && ring_cnt_q == RING_MAX) begin
                    state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = '0;
`endif
                end else if (sec_adv) begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (stop || !alarm_arm) begin
                    state_d = ST_IDLE;
                end else if (sec_adv) begin
                    if (snz_cnt_q == SNZ_MAX) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    assign hh         = hh_q;
    assign mm         = mm_q;
    assign ss         = ss_q;
    assign sec_pulse  = sec_pulse_q;
    assign alarm_ring = (state_q == ST_RINGING);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scoreboard bench for alarm_timekeeper; reference model tracks time as seconds of day.
module tb_alarm_timekeeper;
    localparam int TPS    = 4;
    localparam int RING_S = 60;
    localparam int SNZ_S  = 300;

    logic       clk = 1'b0;
    logic       rst, clk_100hz, set_en, alarm_arm, stop, snooze;
    logic [4:0] set_hh, alarm_hh, hh;
    logic [5:0] set_mm, alarm_mm, mm, ss;
    logic       sec_pulse, alarm_ring;

    always #5 clk = ~clk;

    alarm_timekeeper #(.TICKS_PER_SEC(TPS), .RING_SECONDS(RING_S), .SNOOZE_MINUTES(5)) dut (
        .clk(clk), .rst(rst), .clk_100hz(clk_100hz), .set_en(set_en),
        .set_hh(set_hh), .set_mm(set_mm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_arm(alarm_arm), .stop(stop), .snooze(snooze),
        .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse), .alarm_ring(alarm_ring)
    );

    typedef struct {
        int tod;
        bit ring;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses   = 0;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing
    int tod = 0, sub_m = 0, mode = 0, ring_secs = 0, snz_secs = 0, alarm_tod = 0;
    bit arm_m = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    function automatic int dut_tod();
        return int'(hh) * 3600 + int'(mm) * 60 + int'(ss);
    endfunction

    function automatic void model_second();
        tod = (tod + 1) % 86400;
        case (mode)
            1: begin
                ring_secs++;
                if (ring_secs == RING_S) mode = 0;
            end
            2: begin
                snz_secs++;
                if (snz_secs == SNZ_S) begin
                    mode = 1;
                    ring_secs = 0;
                end
            end
            default: if (arm_m && tod == alarm_tod) begin
                mode = 1;
                ring_secs = 0;
            end
        endcase
    endfunction

    task automatic tick();
        if (!set_en) begin
            sub_m++;
            if (sub_m == TPS) begin
                sub_m = 0;
                model_second();
                sbq.push_back('{tod: tod, ring: (mode == 1)});
            end
        end
        clk_100hz = 1'b1;
        repeat (2) @(negedge clk);
        clk_100hz = 1'b0;
        repeat ($urandom_range(4, 7)) @(negedge clk);
    endtask

    task automatic seconds(input int n);
        repeat (n * TPS) tick();
    endtask

    task automatic load(input int h, input int m);
        set_hh = 5'(h);
        set_mm = 6'(m);
        set_en = 1'b1;
        repeat (2) @(negedge clk);
        set_en = 1'b0;
        tod    = ((h > 23) ? 23 : h) * 3600 + ((m > 59) ? 59 : m) * 60;
        sub_m  = 0;
        @(negedge clk);
    endtask

    task automatic set_alarm(input int h, input int m);
        alarm_hh  = 5'(h);
        alarm_mm  = 6'(m);
        alarm_tod = h * 3600 + m * 60;
    endtask

    task automatic set_arm(input bit a);
        alarm_arm = a;
        arm_m     = a;
        if (!a) mode = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        mode = 0;
        @(negedge clk);
    endtask

    task automatic do_snooze();
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        if (mode == 1) begin
            mode = 2;
            snz_secs = 0;
        end
`endif
        @(negedge clk);
    endtask

    // Monitor: every seconds increment pops one expected time, then checks the settled ring state
    initial begin
        forever begin
            @(negedge clk);
            if (sec_pulse === 1'b1) begin
                pulses++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sec_pulse: got unexpected pulse at %0d, required none", dut_tod());
                end else begin
                    mon_e = sbq.pop_front();
                    $display("sec %02d:%02d:%02d ring=%0b", hh, mm, ss, alarm_ring);
                    check("time", dut_tod(), mon_e.tod);
                    @(negedge clk);
                    check("ring_after_sec", int'(alarm_ring), int'(mon_e.ring));
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b1; clk_100hz = 1'b0; set_en = 1'b0; set_hh = '0; set_mm = '0;
        alarm_hh = '0; alarm_mm = '0; alarm_arm = 1'b0; stop = 1'b0; snooze = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hh", int'(hh), 0);
        check("rst_mm", int'(mm), 0);
        check("rst_ss", int'(ss), 0);
        check("rst_ring", int'(alarm_ring), 0);
        check("rst_pulse", int'(sec_pulse), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        load(23, 59);
        p0 = pulses;
        seconds(60);
        check("wrap_pulses", pulses - p0, 60);
        check("wrap_time", dut_tod(), 0);

        set_hh = 5'd30; set_mm = 6'd63; set_en = 1'b1;
        repeat (2) @(negedge clk);
        p0 = pulses;
        repeat (8) tick();
        check("clamp_hh", int'(hh), 23);
        check("clamp_mm", int'(mm), 59);
        check("clamp_ss", int'(ss), 0);
        check("clamp_pulses", pulses - p0, 0);
        set_en = 1'b0;
        tod = 23 * 3600 + 59 * 60;
        sub_m = 0;
        @(negedge clk);

        set_alarm(7, 0);
        set_arm(1'b1);
        load(6, 59);
        seconds(58);
        check("pre_alarm_time", dut_tod(), 6 * 3600 + 59 * 60 + 58);
        check("pre_alarm_ring", int'(alarm_ring), 0);
        seconds(2);
        check("alarm_ring", int'(alarm_ring), 1);
        do_stop();
        check("stop_ring", int'(alarm_ring), 0);

        load(6, 59);
        seconds(60 + 59);
        check("autostop_before", int'(alarm_ring), 1);
        seconds(1);
        check("autostop_after", int'(alarm_ring), 0);
        check("autostop_time", dut_tod(), 7 * 3600 + 60);

        load(6, 59);
        seconds(61);
        check("disarm_before", int'(alarm_ring), 1);
        set_arm(1'b0);
        check("disarm_ring", int'(alarm_ring), 0);
        set_arm(1'b1);

        load(6, 59);
        seconds(61);
        do_snooze();
`ifdef ALARM_SNOOZE_EN
        check("snooze_ring", int'(alarm_ring), 0);
        seconds(SNZ_S - 1);
        check("snooze_wait", int'(alarm_ring), 0);
        seconds(1);
        check("snooze_rering", int'(alarm_ring), 1);
        stop = 1'b1; snooze = 1'b1;
        @(negedge clk);
        stop = 1'b0; snooze = 1'b0;
        mode = 0;
        @(negedge clk);
        check("stop_snooze_ring", int'(alarm_ring), 0);
`else
        check("snooze_ignored", int'(alarm_ring), 1);
        do_stop();
        check("stop_after_snooze", int'(alarm_ring), 0);
`endif

        for (int i = 0; i < 4; i++) begin
            int h, m, at;
            do_stop();
            h  = $urandom_range(0, 23);
            m  = $urandom_range(0, 59);
            at = (h * 3600 + m * 60 + 60 * $urandom_range(1, 2)) % 86400;
            set_alarm(at / 3600, (at / 60) % 60);
            set_arm(($urandom % 4) != 0);
            load(h, m);
            seconds($urandom_range(60, 120));
            if ($urandom % 2 == 1) begin
                do_stop();
                check("rand_stop_ring", int'(alarm_ring), 0);
            end
            seconds(2);
            check("rand_ring", int'(alarm_ring), int'(mode == 1));
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
